// File: rtl/cannon_matmul_array.sv
// Cannon's-algorithm N x N integer matrix multiplier on a SQRT_P x SQRT_P PE grid.
// Tiles are skewed on load, then alternate serial-k MAC rounds with A-left / B-up rotations.
module cannon_matmul_array #(
  parameter int N      = 4,
  parameter int SQRT_P = 2,
  parameter int W      = 32,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W*N*N-1:0]       matrix_A,
  input  logic [W*N*N-1:0]       matrix_B,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W*N*N-1:0]   matrix_C
);

  localparam int Q  = SQRT_P;
  localparam int NB = N / SQRT_P;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = (Q > 1) ? $clog2(Q) : 1;

  generate
    if (N % SQRT_P != 0) begin : g_bad_cfg
      $error("cannon_matmul_array: N must be a multiple of SQRT_P");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMPUTE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [RW-1:0]          round_q, round_d;
  logic [W-1:0]           a_q   [Q][Q][NB][NB];
  logic [W-1:0]           a_d   [Q][Q][NB][NB];
  logic [W-1:0]           b_q   [Q][Q][NB][NB];
  logic [W-1:0]           b_d   [Q][Q][NB][NB];
  logic [ACC_W-1:0]       acc_q [Q][Q][NB][NB];
  logic [ACC_W-1:0]       acc_d [Q][Q][NB][NB];
  logic [ACC_W*N*N-1:0]   c_q, c_d;

  // Low 2W bits of the product are identical for signed and unsigned once operands are extended.
  function automatic logic [ACC_W-1:0] mac_term(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0]       xe, ye, p;
    logic [2*W+ACC_W-1:0] pe;
    if (SIGNED != 0) begin
      xe = {{W{x[W-1]}}, x};
      ye = {{W{y[W-1]}}, y};
    end else begin
      xe = {{W{1'b0}}, x};
      ye = {{W{1'b0}}, y};
    end
    p  = xe * ye;
    pe = (SIGNED != 0) ? {{ACC_W{p[2*W-1]}}, p} : {{ACC_W{1'b0}}, p};
    return pe[ACC_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    round_d = round_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COMPUTE;
          k_d     = '0;
          round_d = '0;
          for (int i = 0; i < Q; i++)
            for (int j = 0; j < Q; j++)
              for (int r = 0; r < NB; r++)
                for (int c = 0; c < NB; c++) begin
                  a_d[i][j][r][c]   = matrix_A[((i*NB + r)*N + ((i+j)%Q)*NB + c)*W +: W];
                  b_d[i][j][r][c]   = matrix_B[((((i+j)%Q)*NB + r)*N + j*NB + c)*W +: W];
                  acc_d[i][j][r][c] = '0;
                end
        end
      end
      COMPUTE: begin
        for (int i = 0; i < Q; i++)
          for (int j = 0; j < Q; j++)
            for (int r = 0; r < NB; r++)
              for (int c = 0; c < NB; c++)
                acc_d[i][j][r][c] = acc_q[i][j][r][c] +
                                    mac_term(a_q[i][j][r][k_q], b_q[i][j][k_q][c]);
        if (k_q == KW'(NB-1)) begin
          k_d = '0;
          if (round_q == RW'(Q-1)) begin
            state_d = DONE;
            // Result captured from the final accumulation so it is valid alongside done.
            for (int i = 0; i < Q; i++)
              for (int j = 0; j < Q; j++)
                for (int r = 0; r < NB; r++)
                  for (int c = 0; c < NB; c++)
                    c_d[((i*NB + r)*N + j*NB + c)*ACC_W +: ACC_W] = acc_d[i][j][r][c];
          end else begin
            state_d = SHIFT;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      SHIFT: begin
        for (int i = 0; i < Q; i++)
          for (int j = 0; j < Q; j++)
            for (int r = 0; r < NB; r++)
              for (int c = 0; c < NB; c++) begin
                a_d[i][j][r][c] = a_q[i][(j+1)%Q][r][c];
                b_d[i][j][r][c] = b_q[(i+1)%Q][j][r][c];
              end
        round_d = round_q + 1'b1;
        state_d = COMPUTE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      round_q <= '0;
      c_q     <= '0;
      for (int i = 0; i < Q; i++)
        for (int j = 0; j < Q; j++)
          for (int r = 0; r < NB; r++)
            for (int c = 0; c < NB; c++) begin
              a_q[i][j][r][c]   <= '0;
              b_q[i][j][r][c]   <= '0;
              acc_q[i][j][r][c] <= '0;
            end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      round_q <= round_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign matrix_C = c_q;

endmodule

// File: tb/tb_cannon_matmul_array.sv
// Directed bench for cannon_matmul_array: default grid, 8-bit signed/unsigned and a 1x1 grid.
module tb_cannon_matmul_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   start_v;
  wire  [3:0]   busy_v, done_v;
  logic [511:0] a0, b0, a3, b3;
  wire  [511:0] c0, c3;
  logic [127:0] a1, b1, a2, b2;
  wire  [255:0] c1, c2;

  int checks   = 0;
  int failures = 0;

  cannon_matmul_array #(.N(4), .SQRT_P(2), .W(32), .ACC_W(32), .SIGNED(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .matrix_A(a0), .matrix_B(b0),
    .busy(busy_v[0]), .done(done_v[0]), .matrix_C(c0));

  cannon_matmul_array #(.N(4), .SQRT_P(2), .W(8), .ACC_W(16), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .matrix_A(a1), .matrix_B(b1),
    .busy(busy_v[1]), .done(done_v[1]), .matrix_C(c1));

  cannon_matmul_array #(.N(4), .SQRT_P(2), .W(8), .ACC_W(16), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .matrix_A(a2), .matrix_B(b2),
    .busy(busy_v[2]), .done(done_v[2]), .matrix_C(c2));

  cannon_matmul_array #(.N(4), .SQRT_P(1), .W(32), .ACC_W(32), .SIGNED(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .matrix_A(a3), .matrix_B(b3),
    .busy(busy_v[3]), .done(done_v[3]), .matrix_C(c3));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rep32(input logic [31:0] v);
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = v;
    return m;
  endfunction

  function automatic logic [511:0] ramp32();
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = 32'(k + 1);
    return m;
  endfunction

  function automatic logic [511:0] ident32();
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = (k % 5 == 0) ? 32'd1 : 32'd0;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one job on DUT d, checks the done cycle, busy length and the return to idle.
  task automatic run_job(input int d, input string tag, input int exp_cyc);
    int cyc, nbusy;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (cyc <= 20) begin
      if (busy_v[d]) nbusy++;
      if (done_v[d]) break;
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, 512'(cyc), 512'(exp_cyc));
    check({tag, "_busy_cycles"}, 512'(nbusy), 512'(exp_cyc));
    tick();
    check({tag, "_idle_after"}, {510'd0, busy_v[d], done_v[d]}, 512'd0);
  endtask

  initial begin
    int ndone, done_at;
    rst_n   = 1'b0;
    start_v = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    #12;
    check("reset_busy", {508'd0, busy_v}, 512'd0);
    check("reset_done", {508'd0, done_v}, 512'd0);
    check("reset_c0", c0, 512'd0);
    check("reset_c1_c2", {c1, c2}, 512'd0);
    rst_n = 1'b1;
    tick();

    // Identity times ramp
    a0 = ident32();
    b0 = ramp32();
    run_job(0, "ident", 6);
    check("ident_c", c0, ramp32());

    // Constant matrices, then a second job while C must hold the previous result
    a0 = rep32(32'd2);
    b0 = rep32(32'd3);
    run_job(0, "const24", 6);
    check("const24_c", c0, rep32(32'd24));
    a0 = rep32(32'd1);
    b0 = rep32(32'd1);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int cyc = 1; cyc < 6; cyc++) begin
      check("const_hold", c0, rep32(32'd24));
      tick();
    end
    check("const4_done", {511'd0, done_v[0]}, 512'd1);
    check("const4_c", c0, rep32(32'd4));
    tick();

    // Handshake: start pulses in COMPUTE and DONE plus a mid-job A change are ignored
    a0 = ident32();
    b0 = ramp32();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    ndone   = 0;
    done_at = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (done_v[0]) begin
        ndone++;
        done_at = cyc;
      end
      start_v[0] = (cyc == 2 || cyc == 6);
      if (cyc == 2) a0 = rep32(32'd5);
      tick();
    end
    start_v[0] = 1'b0;
    check("hs_done_count", 512'(ndone), 512'd1);
    check("hs_done_cycle", 512'(done_at), 512'd6);
    check("hs_idle", {511'd0, busy_v[0]}, 512'd0);
    check("hs_c", c0, ramp32());

    // Asynchronous reset during the SHIFT cycle
    a0 = ident32();
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {511'd0, busy_v[0]}, 512'd0);
    check("rst_done", {511'd0, done_v[0]}, 512'd0);
    check("rst_c", c0, 512'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run_job(0, "post_rst", 6);
    check("post_rst_c", c0, ramp32());

    // 8-bit signed and unsigned wrap-around
    a1 = {16{8'd127}};
    b1 = {16{8'd127}};
    run_job(1, "s8", 6);
    check("s8_c", {256'd0, c1}, {256'd0, {16{16'hFC04}}});
    a2 = {16{8'hFF}};
    b2 = {16{8'hFF}};
    run_job(2, "u8", 6);
    check("u8_c", {256'd0, c2}, {256'd0, {16{16'hF804}}});

    // Degenerate 1x1 grid
    a3 = ident32();
    b3 = ramp32();
    run_job(3, "q1", 5);
    check("q1_c", c3, ramp32());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cannon_matmul_array.md
Name: cannon_matmul_array

Overview:
- Parametrised Cannon's-algorithm matrix multiplier: computes C = A x B for N x N integer matrices on a SQRT_P x SQRT_P grid of processing elements (PEs).
- Each PE holds one NB x NB tile of A and one of B (NB = N/SQRT_P).
- Generalised successor of the tile-distribution/shift array: adds an initial skew, a per-round serial-k multiply-accumulate, a start/busy/done handshake, reset, and a signed/unsigned mode.
- Sits between the matrix load path and the result writeback path.

Parameters:
- N, 4, matrix dimension.
- SQRT_P, 2, PE grid dimension. N mod SQRT_P must be 0, otherwise elaboration fails.
- W, 32, element width of A and B.
- ACC_W, 32, accumulator and result element width.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin; sampled only in IDLE.
- matrix_A  in  W*N*N  flattened A; element (r,c) at bits [(r*N+c)*W +: W].
- matrix_B  in  W*N*N  flattened B; same layout as matrix_A.
- busy  out  1  high in COMPUTE, SHIFT and DONE.
- done  out  1  one-cycle pulse; high only in DONE.
- matrix_C  out  ACC_W*N*N  flattened result; element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W].

Behaviour:
- Derived constants: NB = N/SQRT_P; Q = SQRT_P. Tile (i,j) of a matrix = rows i*NB..i*NB+NB-1, cols j*NB..j*NB+NB-1.
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, matrix_C=0, all tile and accumulator registers=0, k=0, round=0. Reset takes effect mid-operation with no completion and no done pulse.
- States: IDLE, COMPUTE, SHIFT, DONE.
- IDLE, start=1 at posedge (load edge):
  - PE(i,j) loads A tile (i,(i+j) mod Q) and B tile ((i+j) mod Q, j). This is the Cannon skew.
  - All accumulators clear to 0; k=0, round=0; next state COMPUTE.
  - matrix_A/matrix_B are sampled only at this edge; later changes are ignored.
- COMPUTE, each edge: every PE does acc[r][c] += a[r][k] * b[k][c] for all r,c in 0..NB-1; then k increments.
  - When k==NB-1: if round==Q-1 go to DONE, else go to SHIFT. k resets to 0.
- SHIFT, one edge:
  - A tiles rotate left: PE(i,j) takes A from PE(i,(j+1) mod Q).
  - B tiles rotate up: PE(i,j) takes B from PE((i+1) mod Q, j).
  - round increments; next state COMPUTE.
  - No SHIFT follows the last round; with Q=1 the SHIFT state is never entered.
- DONE, one cycle:
  - matrix_C is loaded from the accumulators on the edge entering DONE, so it is valid while done=1.
  - done=1; next state IDLE.
- Latency: Q*NB COMPUTE cycles plus Q-1 SHIFT cycles, then DONE. For the defaults, done is high in the 6th cycle after the load edge. busy lasts Q*NB+Q cycles.
- matrix_C holds its value until the next DONE or reset. It does not change during a subsequent computation.
- start while busy (COMPUTE/SHIFT/DONE) is ignored and not queued. start held high continuously begins a new job on the first IDLE cycle after DONE.
- Arithmetic:
  - The W x W product is 2W bits, signed or unsigned per SIGNED.
  - The product is sign- or zero-extended, or truncated, to ACC_W; accumulation wraps modulo 2^ACC_W.
  - No saturation and no overflow flag.
- The datapath is combinational per COMPUTE cycle: NB*NB MACs per PE, SQRT_P^2 PEs.

Test Plan:
- Identity check (defaults): A=identity, B=row-major 1..16, one start → done in the 6th cycle after the load edge; matrix_C == B; busy high exactly 6 cycles.
- Constant matrices (defaults): A all 2, B all 3 → every C element = 24. Then a second job with A all 1, B all 1 → all 4; C holds 24 until that DONE edge.
- Signed wrap (W=8, ACC_W=16, SIGNED=1): A=B all 127 → every element 0xFC04 (64516, i.e. -1020). Unsigned (SIGNED=0): A=B all 255 → every element 0xF804 (63492).
- Handshake: pulse start again during COMPUTE and during DONE, and change matrix_A mid-job → both ignored; result reflects the original A; exactly one done pulse.
- Reset mid-operation: assert rst_n=0 asynchronously in the SHIFT cycle → busy, done and matrix_C go to 0 immediately. A fresh start after release produces the correct result (identity case).
- Degenerate grid (SQRT_P=1, N=4): identity x B → SHIFT never entered; done in the 5th cycle after the load edge; matrix_C == B.
